// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with DEPTH slots, per-slot valid,
// a side-channel clear mask, saturating bubble/flush counters and a sticky stall-protocol flag.
module pipe_stage_reg #(
  parameter int                 DATA_W        = 160,
  parameter int                 SIDE_W        = 134,
  parameter int                 DEPTH         = 1,
  parameter logic [SIDE_W-1:0]  SIDE_CLR_MASK = {SIDE_W{1'b0}},
  parameter int                 CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_up,
  input  logic              stall_dn,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SIDE_W-1:0] out_side,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_ADVANCE
  } action_e;

  action_e           action;
  logic              valid_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [SIDE_W-1:0] side_q  [DEPTH];

  // Exactly one action per edge; flush outranks any stall.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    action = ACT_ADVANCE;
    if (flush)         action = ACT_FLUSH;
    else if (stall_dn) action = ACT_HOLD;
    else if (stall_up) action = ACT_BUBBLE;
  end

  // NOTE: the slot array is reset explicitly because a flushed or reset stage must
  // present zero payload, not whatever the previous instruction left behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignments keep every slot update parallel on the edge.
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        side_q[i]  <= '0;
      end
    end else begin
      case (action)
        ACT_FLUSH: begin
          for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            data_q[i]  <= '0;
            side_q[i]  <= '0;
          end
        end
        ACT_HOLD: ;
        ACT_BUBBLE, ACT_ADVANCE: begin
          for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
            side_q[i]  <= side_q[i-1];
          end
          if (action == ACT_BUBBLE) begin
            // Multi-cycle ops keep their temporaries across a bubble.
            valid_q[0] <= 1'b0;
            data_q[0]  <= '0;
            side_q[0]  <= in_side;
          end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            side_q[0]  <= in_side & ~SIDE_CLR_MASK;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (action == ACT_BUBBLE && bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (action == ACT_FLUSH && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + CNT_W'(1);
      // A downstream stall without the upstream one breaks the monotonic stall vector.
      if (action == ACT_HOLD && !stall_up)
        proto_err <= 1'b1;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_side  = side_q[DEPTH-1];

endmodule
